// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bit-serial adder sequencer: accepts a/b/cin, streams one bit pair per clock
// LSB first through a one-bit full-adder cell, then presents {cout,sum}.

module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    generate
        if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH must be in 2..64");
        end
    endgenerate

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             cell_s;
    logic             cell_co;

    serial_adder_fa u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            psum   <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    // sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= {cell_s, psum[WIDTH-1:1]};
                    carry <= cell_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum_q  <= {cell_s, psum[WIDTH-1:1]};
                        cout_q <= cell_co;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
// Bench for serial_adder_ctrl: directed vectors and corner sequences at WIDTH=8,
// plus randomized handshake sweeps at WIDTH=8 and WIDTH=13 against a+b+cin.

module tb_serial_adder_ctrl;
    localparam int NOPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, iv8, ir8, ci8, ov8, or8, co8, bz8;
    logic [7:0] a8, b8, s8;
    logic        rst13, iv13, ir13, ci13, ov13, or13, co13, bz13;
    logic [12:0] a13, b13, s13;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
    );
    serial_adder_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst13), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
        .cin(ci13), .out_valid(ov13), .out_ready(or13), .sum(s13), .cout(co13), .busy(bz13)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboards: model is plain arithmetic on the operands seen at accept
    logic [63:0] q8[$];
    logic [63:0] q13[$];
    logic sw8 = 1'b0, sw13 = 1'b0;
    logic pov8 = 1'b0, pwait8 = 1'b0, pov13 = 1'b0, pwait13 = 1'b0;
    logic [8:0]  ps8;
    logic [13:0] ps13;

    always @(negedge clk) begin
        if (sw8 && !rst8) begin
            if (iv8 && ir8) q8.push_back(64'(a8) + 64'(b8) + 64'(ci8));
            if (ov8 && !pov8) chk("sweep8 valid_after_accept", 64'(q8.size() != 0), 64'd1);
            if (ov8 && pwait8) chk("sweep8 hold", 64'({co8, s8}), 64'(ps8));
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("sweep8 spurious_result", 64'd1, 64'd0);
                else chk("sweep8 result", 64'({co8, s8}), q8.pop_front());
            end
            pov8   <= ov8;
            pwait8 <= ov8 && !or8;
            ps8    <= {co8, s8};
        end
    end

    always @(negedge clk) begin
        if (sw13 && !rst13) begin
            if (iv13 && ir13) q13.push_back(64'(a13) + 64'(b13) + 64'(ci13));
            if (ov13 && !pov13) chk("sweep13 valid_after_accept", 64'(q13.size() != 0), 64'd1);
            if (ov13 && pwait13) chk("sweep13 hold", 64'({co13, s13}), 64'(ps13));
            if (ov13 && or13) begin
                if (q13.size() == 0) chk("sweep13 spurious_result", 64'd1, 64'd0);
                else chk("sweep13 result", 64'({co13, s13}), q13.pop_front());
            end
            pov13   <= ov13;
            pwait13 <= ov13 && !or13;
            ps13    <= {co13, s13};
        end
    end

    // one full operation with exact latency checks; DUT must start in IDLE
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec, input string nm);
        @(posedge clk); #1;
        a8 = a; b8 = b; ci8 = ci; iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk); chk({nm, " in_ready"}, 64'(ir8), 64'd1);
        @(posedge clk); #1 iv8 = 1'b0;
        @(negedge clk);
        chk({nm, " busy_after_accept"}, 64'(bz8), 64'd1);
        chk({nm, " in_ready_in_add"}, 64'(ir8), 64'd0);
        repeat (7) @(posedge clk);
        @(negedge clk); chk({nm, " out_valid_early"}, 64'(ov8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid"}, 64'(ov8), 64'd1);
        chk({nm, " sum"}, 64'(s8), 64'(es));
        chk({nm, " cout"}, 64'(co8), 64'(ec));
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid_after"}, 64'(ov8), 64'd0);
        chk({nm, " idle_ready"}, 64'(ir8), 64'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic run_directed8();
        vec_t tv[6];
        tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tv[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        for (int i = 0; i < 6; i++) op8(tv[i].a, tv[i].b, tv[i].ci, tv[i].s, tv[i].co, $sformatf("vec%0d", i));

        // backpressure: result held, new operands refused
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk); #1 iv8 = 1'b0;
        repeat (8) @(posedge clk);
        #1 iv8 = 1'b1; a8 = 8'h01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp sum c%0d", k), 64'(s8), 64'h30);
            chk($sformatf("bp out_valid c%0d", k), 64'(ov8), 64'd1);
            chk($sformatf("bp in_ready c%0d", k), 64'(ir8), 64'd0);
            @(posedge clk);
        end
        #1 or8 = 1'b1; iv8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp idle in_ready", 64'(ir8), 64'd1);
        chk("bp idle out_valid", 64'(ov8), 64'd0);
        chk("bp sum kept", 64'(s8), 64'h30);
        repeat (3) @(negedge clk);
        chk("bp no second op", 64'(bz8), 64'd0);

        // reset in the third ADD cycle discards the operation
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1 iv8 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid out_valid", 64'(ov8), 64'd0);
        chk("rst_mid busy", 64'(bz8), 64'd0);
        chk("rst_mid sum", 64'(s8), 64'h00);
        chk("rst_mid cout", 64'(co8), 64'd0);
        chk("rst_mid in_ready", 64'(ir8), 64'd0);
        @(posedge clk); #1 rst8 = 1'b0;
        @(negedge clk); chk("rst_mid ready_after", 64'(ir8), 64'd1);
        op8(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, "after_rst");

        // in_valid held through ADD with changing operands
        @(posedge clk); #1;
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1; iv8 = 1'b1; or8 = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            #1 a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            @(posedge clk);
        end
        #1 iv8 = 1'b0;
        @(negedge clk);
        chk("ignore out_valid", 64'(ov8), 64'd1);
        chk("ignore result", 64'({co8, s8}), 64'h047);
        @(posedge clk); #1 or8 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ignore single_result c%0d", k), 64'({ov8, bz8}), 64'd0);
        end
    endtask

    task automatic sweep8();
        int ops = 0, cyc = 0;
        logic acc;
        sw8 = 1'b1;
        while (ops < NOPS && cyc < 60000) begin
            @(negedge clk); acc = iv8 && ir8;
            @(posedge clk); #1; cyc++;
            or8 = ($urandom_range(0, 3) != 0);
            if (acc) begin iv8 = 1'b0; ops++; end
            if (!iv8 && ops < NOPS && $urandom_range(0, 2) == 0) begin
                a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); iv8 = 1'b1;
            end
        end
        iv8 = 1'b0; or8 = 1'b1;
        for (int k = 0; k < 50 && (q8.size() != 0 || bz8); k++) @(posedge clk);
        @(negedge clk);
        chk("sweep8 ops_done", 64'(ops), 64'(NOPS));
        chk("sweep8 drained", 64'(q8.size()), 64'd0);
    endtask

    task automatic sweep13();
        int ops = 0, cyc = 0;
        logic acc;
        sw13 = 1'b1;
        while (ops < NOPS && cyc < 60000) begin
            @(negedge clk); acc = iv13 && ir13;
            @(posedge clk); #1; cyc++;
            or13 = ($urandom_range(0, 3) != 0);
            if (acc) begin iv13 = 1'b0; ops++; end
            if (!iv13 && ops < NOPS && $urandom_range(0, 2) == 0) begin
                a13 = 13'($urandom); b13 = 13'($urandom); ci13 = 1'($urandom); iv13 = 1'b1;
            end
        end
        iv13 = 1'b0; or13 = 1'b1;
        for (int k = 0; k < 50 && (q13.size() != 0 || bz13); k++) @(posedge clk);
        @(negedge clk);
        chk("sweep13 ops_done", 64'(ops), 64'(NOPS));
        chk("sweep13 drained", 64'(q13.size()), 64'd0);
    endtask

    initial begin
        rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        rst13 = 1'b1; iv13 = 1'b0; or13 = 1'b0; a13 = '0; b13 = '0; ci13 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(ov8), 64'd0);
        chk("reset busy", 64'(bz8), 64'd0);
        chk("reset result", 64'({co8, s8}), 64'd0);
        chk("reset in_ready", 64'(ir8), 64'd0);
        chk("reset13 state", 64'({ov13, bz13, ir13}), 64'd0);
        @(posedge clk); #1 rst8 = 1'b0; rst13 = 1'b0;
        @(negedge clk);
        chk("reset release in_ready", 64'(ir8), 64'd1);
        chk("reset13 release in_ready", 64'(ir13), 64'd1);
        fork
            begin
                run_directed8();
                sweep8();
            end
            sweep13();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder built around a one-bit full-adder cell. Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. Feeds one bit pair per clock, LSB first, into the cell, with the carry registered between bits. Returns the WIDTH-bit sum and final carry-out on a valid/ready output handshake. It is the sequencing stage that feeds the cell and consumes its sum/carry outputs.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64; elaboration must fail outside this range.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  sum/cout hold a completed result
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result a+b+cin, mod 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
busy  output  1  high in ADD or DONE

Behaviour:
- Reset: rst sampled high at a rising edge forces the following, regardless of current state:
  - state=IDLE, bit counter=0, carry register=0;
  - operand shift registers=0, result registers sum=0 and cout=0;
  - out_valid=0, busy=0.
  - in_ready is 0 while rst is high and 1 in the cycle after rst deasserts.
- FSM states: IDLE, ADD, DONE.
  - in_ready = (state==IDLE) && !rst.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE: when in_valid && in_ready at an edge:
  - load the A and B shift registers;
  - carry register <= cin, counter <= 0;
  - go to ADD.
  - Otherwise stay in IDLE. sum/cout keep their last result.
- ADD: each cycle the cell gets A[0], B[0] and the carry register. At the edge:
  - the sum bit shifts into the MSB of the partial-sum shift register (right shift);
  - A and B shift right by 1;
  - carry register <= cell carry-out;
  - counter increments.
  - When counter==WIDTH-1 at the edge: sum <= final partial sum including this bit, cout <= cell carry-out, go to DONE.
  - in_valid is ignored throughout ADD.
- DONE: out_valid=1; sum and cout held stable.
  - When out_ready is high at an edge, go to IDLE.
  - in_valid is ignored; in_ready=0 (no same-cycle turnaround).
- Latency:
  - operands accepted at edge T; out_valid first high in the cycle after edge T+WIDTH.
  - Minimum spacing between accepts is WIDTH+2 cycles (1 IDLE, WIDTH ADD, at least 1 DONE).
- Arithmetic: {cout,sum} = a + b + cin, computed over WIDTH+1 bits. No signed interpretation; overflow is reported only through cout.
- Result registers change only on the ADD->DONE transition or reset. Partial values are never visible on sum/cout.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.
- Reset mid-operation (ADD or DONE): the operation is discarded with no output. The block returns to IDLE and the next accepted operation computes correctly.
- out_ready high outside DONE has no effect.

Test Plan:
- WIDTH=8; a=8'h5A, b=8'h3C, cin=0, accepted at edge T, out_ready=1 -> out_valid high after edge T+8; sum=8'h96, cout=0; back to IDLE one edge later.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure: a=8'h10, b=8'h20, out_ready=0 for 5 cycles in DONE, in_valid pulsed with a=8'h01 -> sum=8'h30 stable all 5 cycles, in_ready=0, second operand not accepted. Raise out_ready -> IDLE, then in_ready=1.
- Reset mid-op: accept a=8'hAA, b=8'h55, rst=1 at the 3rd ADD cycle -> next cycle out_valid=0, busy=0, sum=8'h00, cout=0. Then a=8'h01, b=8'h01, cin=1 -> sum=8'h03, cout=0.
- Ignored inputs: in_valid held high through ADD with changing a/b -> result reflects only the operands sampled at the accept edge; exactly one result per accept.
- Random sweep, WIDTH=8 and WIDTH=13, 1000 operations with random valid/ready gaps -> {cout,sum} matches the a+b+cin model every time; out_valid never asserts without a prior accept.
